// File: rtl/regfile_mp.sv
// Multi-port GPR file: two prioritised write ports, N combinational read
// ports with optional write bypass, and a per-register pending scoreboard.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rd_addr/rd_data   NUM_RD packed read ports (combinational)
//   rd_busy           per-port pending flag of the addressed register
//   wr0_*/wr1_*       write ports; port 1 wins on an address collision;
//                     wrN_clr marks the write as a writeback (clears pend)
//   iss_en/iss_addr   issue: mark destination pending
//   pend_vec          registered pending bits
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr0_clr,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     wr1_clr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [NUM_REGS-1:0]      pend_vec
);

    if (NUM_REGS != (1 << ADDR_W)) begin : g_chk_addr
        $error("regfile_mp: NUM_REGS must equal 2**ADDR_W");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_chk_rd
        $error("regfile_mp: NUM_RD must be 1..4");
    end

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;

    logic [NUM_REGS-1:0] w_wr0_sel;
    logic [NUM_REGS-1:0] w_wr1_sel;
    logic [NUM_REGS-1:0] w_clr_hit;
    logic [NUM_REGS-1:0] w_set_hit;
    logic [NUM_REGS-1:0] w_pend_nxt;

    // One-hot decode of every port. Register 0 is masked out here so that
    // storage, scoreboard and bypass all see it as untouchable.
    always_comb begin
        w_wr0_sel = '0;
        w_wr1_sel = '0;
        w_clr_hit = '0;
        w_set_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wr0_sel[r] = wr0_en && (wr0_addr == ADDR_W'(r));
            w_wr1_sel[r] = wr1_en && (wr1_addr == ADDR_W'(r));
            w_clr_hit[r] = (w_wr0_sel[r] && wr0_clr) ||
                           (w_wr1_sel[r] && wr1_clr);
            w_set_hit[r] = iss_en && (iss_addr == ADDR_W'(r));
        end
        if (ZERO_REG != 0) begin
            w_wr0_sel[0] = 1'b0;
            w_wr1_sel[0] = 1'b0;
            w_clr_hit[0] = 1'b0;
            w_set_hit[0] = 1'b0;
        end
    end

    // Set after clear: a fresh issue supersedes a retiring producer.
    assign w_pend_nxt = (r_pend & ~w_clr_hit) | w_set_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_mem[r] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_wr1_sel[r]) begin
                    r_mem[r] <= wr1_data;
                end else if (w_wr0_sel[r]) begin
                    r_mem[r] <= wr0_data;
                end
            end
            r_pend <= w_pend_nxt;
        end
    end

    assign pend_vec = r_pend;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_d;
        logic              w_b;

        assign w_a = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_d = r_mem[w_a];
            w_b = r_pend[w_a];
            if (BYPASS != 0) begin
                if (w_wr1_sel[w_a]) begin
                    w_d = wr1_data;
                end else if (w_wr0_sel[w_a]) begin
                    w_d = wr0_data;
                end
                // Reader sees the writeback data, so it must not stall.
                w_b = r_pend[w_a] & ~w_clr_hit[w_a];
            end
            if (ZERO_REG != 0 && w_a == '0) begin
                w_d = '0;
                w_b = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_d;
        assign rd_busy[k]                  = w_b;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file, the successor to the single-write/dual-read GPR array in the cpu core.
- Configurable data width, register count and read-port count.
- Two write ports with fixed priority and optional write-to-read bypass.
- Per-register pending scoreboard: issue marks a destination busy, writeback clears it. Decode stalls on busy operands.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of registers; power of two, >= 2
ADDR_W, 5, address width; must equal log2(NUM_REGS)
NUM_RD, 2, number of read ports, 1..4
BYPASS, 1, 1 = read returns same-cycle write data on address match; 0 = read returns stored value only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
rd_addr  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, combinational, packed the same way as rd_addr
rd_busy  output  NUM_RD  1 = addressed register is pending (after same-cycle clear/set rules)
wr0_en  input  1  write port 0 enable
wr0_addr  input  ADDR_W  write port 0 address
wr0_data  input  DATA_W  write port 0 data
wr0_clr  input  1  port 0 write is a writeback; clears the pending bit of wr0_addr
wr1_en  input  1  write port 1 enable; port 1 has priority
wr1_addr  input  ADDR_W  write port 1 address
wr1_data  input  DATA_W  write port 1 data
wr1_clr  input  1  port 1 write is a writeback; clears the pending bit of wr1_addr
iss_en  input  1  issue: set the pending bit of iss_addr
iss_addr  input  ADDR_W  issue destination
pend_vec  output  NUM_REGS  current pending bits, registered

Behaviour:
- Reset: sync, active-high. On a clk edge with rst=1:
  - all registers <= 0; pend_vec <= 0.
  - All write, clear and issue inputs in that cycle are ignored.
  - rd_data then shows 0 from the next cycle; rd_busy shows 0.
- Write, registered, takes effect at the next edge:
  - wrN_en=1 writes wrN_data to wrN_addr.
  - Same address on both ports in one cycle: port 1 data is stored; port 0 is dropped.
  - Different addresses: both are stored.
- Register 0 with ZERO_REG=1:
  - writes are discarded; reads return 0 on every port, including bypass.
  - iss_en to address 0 is ignored; rd_busy is 0.
- Read, combinational, zero latency:
  - BYPASS=1:
    - rd_addr matches wr1_addr with wr1_en=1 -> wr1_data.
    - else matches wr0_addr with wr0_en=1 -> wr0_data.
    - else the stored value.
  - BYPASS=0: always the stored value; new data is visible the cycle after the write.
- Scoreboard, registered:
  - next pend[r] = (pend[r] & ~clr_hit[r]) | set_hit[r].
    - clr_hit[r] = (wr0_en & wr0_clr & wr0_addr==r) | (wr1_en & wr1_clr & wr1_addr==r).
    - set_hit[r] = iss_en & iss_addr==r.
  - Issue and clear to the same register in one cycle: set wins, because a new producer supersedes the old one.
  - Write with wrN_clr=0 updates data but leaves pend unchanged.
  - Clear of a register that is not pending has no effect.
  - Issue to an already pending register: stays 1; no counting.
- rd_busy[k]:
  - BYPASS=1: pend[rd_addr_k] & ~clr_hit[rd_addr_k]. A same-cycle writeback is reported not-busy, consistent with the bypassed data.
  - BYPASS=0: pend[rd_addr_k].
  - A same-cycle issue does not raise rd_busy until the next cycle.
- No X propagation: an out-of-range address cannot occur (NUM_REGS = 2^ADDR_W).

Test Plan:
- Reset, then read all regs on every port -> rd_data=0, rd_busy=0, pend_vec=0. Then hold rst=1 with wr0_en=1, addr 3, data 0xDEADBEEF -> reg 3 still 0 after rst drops.
- Write 0x12345678 to reg 5 via port 0 with BYPASS=1, reading reg 5 the same cycle -> rd_data=0x12345678 that cycle. With BYPASS=0 -> old value 0 that cycle, then 0x12345678 the next cycle.
- Both ports write reg 7 the same cycle (port0 0xAAAA_0000, port1 0x5555_1111) -> bypassed read and later stored value both 0x5555_1111.
- Write 0xFFFFFFFF to reg 0 with iss_en to reg 0 -> reg 0 reads 0 on all ports, pend_vec[0]=0.
- iss_en reg 9 -> next cycle pend_vec[9]=1 and rd_busy=1 for a reader of reg 9. Then wr1 writeback to reg 9, data 0x42, clr=1 -> same cycle rd_busy=0 and rd_data=0x42 (BYPASS=1). Next cycle pend_vec[9]=0.
- Same cycle: iss_en reg 4 plus wr0 writeback (clr=1) to reg 4, with pend[4]=1 -> pend_vec[4] stays 1. Then a write to reg 4 with clr=0 -> pend_vec[4] still 1, data updated.
